// File: rtl/dvs_fifo_bus_arbiter.sv
// Shared event-FIFO write-port arbiter for the DVS AER-to-event interfaces.
// Round-robin selection over fifo_req with a hold-until-release grant
// handshake. Exactly one registered FIFO write is made per grant, on the
// grant's first cycle. A grant held too long is force-released and flagged.

package dvs_ravens_pkg;
    localparam int EVENT_BITS = 16;
endpackage

module dvs_fifo_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int EVENT_BITS  = dvs_ravens_pkg::EVENT_BITS,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_BITS    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            fifo_req,
    input  logic [N_REQ*EVENT_BITS-1:0] fifo_bus_event,
    input  logic                        fifo_full,
    input  logic                        clear_status,
    output logic [N_REQ-1:0]            fifo_grant,
    output logic                        fifo_wr_en,
    output logic [EVENT_BITS-1:0]       fifo_wr_data,
    output logic [CNT_BITS-1:0]         event_count,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        rr_last;    // last winner; in GRANT it is also the current owner
    logic [TMR_W-1:0]        timer;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand_idx;
    logic                    win_found;
    logic [EVENT_BITS-1:0]   win_event;
    logic                    wr_now;
    logic                    timeout_now;

    // Round-robin search starting one past the last winner, wrapping mod N_REQ
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_last) + k) % N_REQ);
            if (!win_found && fifo_req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Pick the winner's event word out of the flattened bus
    always_comb begin
        win_event = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_event = fifo_bus_event[i*EVENT_BITS +: EVENT_BITS];
            end
        end
    end

    // A write happens only on the deciding IDLE edge with room in the FIFO
    always_comb begin
        wr_now      = (state == IDLE) && win_found && !fifo_full;
        timeout_now = (state == GRANT) && fifo_req[rr_last] &&
                      (timer == TMR_W'(TIMEOUT_CYC - 1));
    end

    // Grant FSM, registered FIFO write, event counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_last      <= IDX_W'(N_REQ - 1);
            timer        <= '0;
            fifo_grant   <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            event_count  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_now) begin
                        fifo_grant   <= N_REQ'(1) << win_idx;
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= win_event;
                        rr_last      <= win_idx;
                        timer        <= '0;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    // Owner released, or it has held the bus for TIMEOUT_CYC cycles
                    if (!fifo_req[rr_last] || timeout_now) begin
                        fifo_grant <= '0;
                        state      <= RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    fifo_grant <= '0;
                    state      <= IDLE;
                end
            endcase

            // Clear beats a same-cycle write; the write is then not counted
            if (clear_status) begin
                event_count <= '0;
            end else if (wr_now) begin
                event_count <= event_count + 1'b1;
            end

            // A new timeout beats a same-cycle clear
            if (timeout_now) begin
                timeout_err <= 1'b1;
            end else if (clear_status) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dvs_fifo_bus_arbiter.sv
// Bench for dvs_fifo_bus_arbiter: directed scenarios plus randomized AER
// traffic. Issued events go into per-requester expectation queues; a negedge
// monitor predicts each round-robin winner from the sampled requests and pops
// and compares on every FIFO write.

module tb_dvs_fifo_bus_arbiter;

    localparam int N  = 4;
    localparam int EB = 16;
    localparam int TO = 64;
    localparam int CB = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      fifo_req;
    logic [N*EB-1:0]   fifo_bus_event;
    logic              fifo_full;
    logic              clear_status;
    logic [N-1:0]      fifo_grant;
    logic              fifo_wr_en;
    logic [EB-1:0]     fifo_wr_data;
    logic [CB-1:0]     event_count;
    logic              timeout_err;

    dvs_fifo_bus_arbiter #(
        .N_REQ(N), .EVENT_BITS(EB), .TIMEOUT_CYC(TO), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_req(fifo_req),
        .fifo_bus_event(fifo_bus_event), .fifo_full(fifo_full),
        .clear_status(clear_status), .fifo_grant(fifo_grant),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .event_count(event_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int issued = 0;
    logic [EB-1:0] exp_q [N][$];
    int grant_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int i, input logic [EB-1:0] ev);
        fifo_bus_event[i*EB +: EB] = ev;
        fifo_req[i] = 1'b1;
        exp_q[i].push_back(ev);
        issued++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) exp_q[i].delete();
        grant_log.delete();
        issued = 0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fifo_req       = '0;
        fifo_bus_event = '0;
        fifo_full      = 1'b0;
        clear_status   = 1'b0;
        cyc(2);
        clear_model();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int i, input int budget, input string name);
        int n;
        n = 0;
        while (!fifo_grant[i] && n < budget) begin
            cyc(1);
            n++;
        end
        chk(name, fifo_grant[i], 1);
    endtask

    // Reference monitor: rotation is "first requester after the previous winner"
    logic [N-1:0] sv_req;
    logic         sv_full;
    int           m_last;
    int           mw;
    int           mc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_last = N - 1;
        end else begin
            checks++;
            if (!(fifo_grant == '0 || $onehot(fifo_grant))) begin
                errors++;
                $display("FAIL grant_onehot: got 0x%0h expected one-hot or zero", fifo_grant);
            end
            if (fifo_wr_en) begin
                mw = -1;
                for (int k = 1; k <= N; k++) begin
                    mc = (m_last + k) % N;
                    if (mw < 0 && sv_req[mc]) mw = mc;
                end
                chk("full_at_decision", sv_full, 0);
                if (mw < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data 0x%0h expected no write", fifo_wr_data);
                end else begin
                    chk("winner_grant", fifo_grant, 64'(1) << mw);
                    m_last = mw;
                    grant_log.push_back(mw);
                    if (exp_q[mw].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_write: got 0x%0h expected nothing pending for req %0d", fifo_wr_data, mw);
                    end else begin
                        chk("wr_data", fifo_wr_data, exp_q[mw].pop_front());
                    end
                end
            end
        end
        sv_req  = fifo_req;
        sv_full = fifo_full;
    end

    // Behavioural AER requesters: raise with an event, drop after a hold, rest
    task automatic run_req(input int cycles, input bit rnd, input int per_req, output bit drained);
        int st[N];
        int cnt[N];
        int done[N];
        bit all_idle;
        for (int i = 0; i < N; i++) begin
            st[i] = 0; cnt[i] = 0; done[i] = 0;
        end
        drained = 1'b0;
        for (int c = 0; c < cycles && !drained; c++) begin
            cyc(1);
            if (rnd) fifo_full = ($urandom_range(0, 9) < 3);
            all_idle = 1'b1;
            for (int i = 0; i < N; i++) begin
                case (st[i])
                    0: if (done[i] < per_req) begin
                        all_idle = 1'b0;
                        if (cnt[i] == 0) begin
                            issue(i, rnd ? EB'($urandom) : EB'(i*256 + done[i]));
                            st[i] = 1;
                        end else begin
                            cnt[i]--;
                        end
                    end
                    1: begin
                        all_idle = 1'b0;
                        if (fifo_grant[i]) begin
                            done[i]++;
                            cnt[i] = rnd ? $urandom_range(0, 3) : 0;
                            st[i]  = 2;
                        end
                    end
                    default: all_idle = 1'b0;
                endcase
                if (st[i] == 2) begin
                    if (cnt[i] == 0) begin
                        fifo_req[i] = 1'b0;
                        cnt[i] = rnd ? $urandom_range(0, 4) : 1;
                        st[i]  = 0;
                    end else begin
                        cnt[i]--;
                    end
                end
            end
            if (all_idle) drained = 1'b1;
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hold;

        // Reset values
        rst_n = 1'b0;
        fifo_req = '0; fifo_bus_event = '0; fifo_full = 1'b0; clear_status = 1'b0;
        #3;
        chk("rst_grant", fifo_grant, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_count", event_count, 0);
        chk("rst_timeout", timeout_err, 0);

        // Single requester, single write
        do_reset();
        cyc(1);
        issue(0, 16'h02A5);
        cyc(1);
        chk("single_grant", fifo_grant, 4'b0001);
        chk("single_wr_en", fifo_wr_en, 1);
        chk("single_wr_data", fifo_wr_data, 16'h02A5);
        fifo_req[0] = 1'b0;
        cyc(1);
        chk("single_release", fifo_grant, 0);
        chk("single_wr_once", fifo_wr_en, 0);
        chk("single_count", event_count, 1);
        cyc(4);

        // All four requesting, rotation 0,1,2,3,0,...
        do_reset();
        run_req(400, 1'b0, 2, ok);
        chk("rot_drained", ok, 1);
        cyc(4);
        chk("rot_grants", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            chk("rot_order", grant_log[k], k % N);
        chk("rot_count", event_count, 8);

        // Back-pressure: no grant while full, grant right after it clears
        do_reset();
        fifo_full = 1'b1;
        issue(2, 16'h0C3C);
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("full_hold", {fifo_grant, fifo_wr_en}, 0);
        end
        fifo_full = 1'b0;
        cyc(1);
        chk("full_release_grant", fifo_grant, 4'b0100);
        chk("full_release_wr", fifo_wr_en, 1);
        fifo_req[2] = 1'b0;
        cyc(4);

        // Grant timeout and sticky error
        do_reset();
        issue(1, 16'h0111);
        wait_grant(1, 10, "to_grant");
        hold = 0;
        while (fifo_grant[1] && hold < 200) begin
            cyc(1);
            hold++;
        end
        fifo_req[1] = 1'b0;
        chk("to_hold_cycles", hold, TO);
        chk("to_err_set", timeout_err, 1);
        cyc(5);
        chk("to_err_sticky", timeout_err, 1);
        clear_status = 1'b1;
        cyc(1);
        clear_status = 1'b0;
        chk("to_err_cleared", timeout_err, 0);
        cyc(2);

        // Asynchronous reset mid-grant, then priority restarts at requester 0
        do_reset();
        issue(3, 16'h0333);
        wait_grant(3, 10, "ar_grant3");
        #2 rst_n = 1'b0;
        #1;
        chk("ar_outputs", {fifo_grant, fifo_wr_en, fifo_wr_data, event_count, timeout_err}, 0);
        clear_model();
        issue(3, 16'h0334);
        issue(0, 16'h0A00);
        cyc(2);
        rst_n = 1'b1;
        wait_grant(0, 10, "ar_grant0");
        chk("ar_first_is_0", fifo_grant, 4'b0001);
        fifo_req[0] = 1'b0;
        wait_grant(3, 10, "ar_grant3_next");
        fifo_req[3] = 1'b0;
        cyc(4);

        // Random traffic with random back-pressure
        do_reset();
        run_req(20000, 1'b1, 25, ok);
        chk("rnd_drained", ok, 1);
        cyc(5);
        for (int i = 0; i < N; i++) chk("rnd_no_loss", exp_q[i].size(), 0);
        chk("rnd_count", event_count, CB'(issued));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
